// File: rtl/core_types_pkg.sv
// Shared types for the core pipeline control path.
//  seq_state_t : sequencer state (RUN, DSTALL, ISTALL)
//  pc_sel_t    : PC mux select (PC_SEQ, PC_REDIRECT)
//  NOP_INSTR   : instruction word loaded when a pipeline bubble is inserted
//  WAIT_W      : width of the D-memory stall wait counter
//  calcTarget  : redirect target computation shared by all redirect paths
package core_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        ISTALL = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'd0,
        PC_REDIRECT = 2'd1
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int WAIT_W = 10;

    // A bypass (JALR) target is absolute with bit 0 forced low; otherwise the
    // target is PC-relative and wraps modulo 2^32.
    function automatic logic [31:0] calcTarget(
        input logic        bypass,
        input logic [31:0] pcNext,
        input logic [31:0] pcCurrent
    );
        logic [31:0] tgt;
        if (bypass) begin
            tgt = {pcNext[31:1], 1'b0};
        end else begin
            tgt = pcCurrent + pcNext;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//  Clock  : core clock, rising edge
//  nReset : asynchronous active-low reset, count returns to zero
//  clear  : synchronous clear (wins over inc)
//  inc    : increment request; ignored once count is all-ones
//  count  : current value, never wraps
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage core.
//  Inputs : flush/hold/branch/bypass requests and PCnext/PCcurrent from the
//           branch unit, imemReady from fetch, dmemReq/dmemReady from memory.
//  Outputs: per-stage register enables (pcEn, ifdecEn, decexeEn, exememEn),
//           bubble inserts (ifdecBubble, decexeBubble), PC select and target,
//           sticky busError on D-stall timeout, saturating flush/stall counts.
// Priority each cycle: D-stall > flush > hold > I-stall > run. A redirect
// seen during an I-fetch stall is parked in pendTarget_r and replayed on the
// cycle the fetch completes.
module pipeline_sequencer
    import core_types_pkg::*;
#(
    parameter int DSTALL_TIMEOUT = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             flush,
    input  logic             hold,
    input  logic             branch,
    input  logic             bypass,
    input  logic [31:0]      PCnext,
    input  logic [31:0]      PCcurrent,
    input  logic             imemReady,
    input  logic             dmemReq,
    input  logic             dmemReady,
    output logic             pcEn,
    output logic             ifdecEn,
    output logic             decexeEn,
    output logic             exememEn,
    output logic             ifdecBubble,
    output logic             decexeBubble,
    output pc_sel_t          pcSel,
    output logic [31:0]      pcTarget,
    output logic             busError,
    output logic [CNT_W-1:0] flushCount,
    output logic [CNT_W-1:0] stallCount
);

    seq_state_t        state_r;
    seq_state_t        nextState_s;
    logic              pendValid_r;
    logic              nextPendValid_s;
    logic [31:0]       pendTarget_r;
    logic [31:0]       nextPendTarget_s;
    logic              busError_r;
    logic [31:0]       target_s;
    logic              dStallReq_s;
    logic              redirectReq_s;
    logic              flushInc_s;
    logic              stallInc_s;
    logic              waitInc_s;
    logic              waitClear_s;
    logic [WAIT_W-1:0] waitCount_s;
    logic              timeoutHit_s;

    assign target_s      = calcTarget(bypass, PCnext, PCcurrent);
    assign dStallReq_s   = dmemReq & ~dmemReady;
    // Anything that must steer the PC: a flush or a hold carrying a redirect.
    assign redirectReq_s = flush | (hold & (branch | bypass));
    // The wait counter holds prior stall cycles, so this is the TIMEOUT-th one.
    assign timeoutHit_s  = waitInc_s && (waitCount_s == WAIT_W'(DSTALL_TIMEOUT - 1));
    assign busError      = busError_r;

    // Next-state and per-cycle control outputs.
    always_comb begin
        nextState_s      = state_r;
        nextPendValid_s  = pendValid_r;
        nextPendTarget_s = pendTarget_r;
        pcEn             = 1'b1;
        ifdecEn          = 1'b1;
        decexeEn         = 1'b1;
        exememEn         = 1'b1;
        ifdecBubble      = 1'b0;
        decexeBubble     = 1'b0;
        pcSel            = PC_SEQ;
        pcTarget         = 32'h0000_0000;
        flushInc_s       = 1'b0;
        stallInc_s       = 1'b0;
        waitInc_s        = 1'b0;
        waitClear_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (dStallReq_s) begin
                    // Freeze everything; upstream regs re-present next cycle.
                    pcEn        = 1'b0;
                    ifdecEn     = 1'b0;
                    decexeEn    = 1'b0;
                    exememEn    = 1'b0;
                    stallInc_s  = 1'b1;
                    waitInc_s   = 1'b1;
                    nextState_s = DSTALL;
                end else if (flush) begin
                    ifdecBubble  = 1'b1;
                    decexeBubble = 1'b1;
                    pcSel        = PC_REDIRECT;
                    pcTarget     = target_s;
                    flushInc_s   = 1'b1;
                end else if (hold) begin
                    ifdecEn      = 1'b0;
                    decexeBubble = 1'b1;
                    if (branch | bypass) begin
                        pcSel    = PC_REDIRECT;
                        pcTarget = target_s;
                    end else begin
                        pcEn = 1'b0;
                    end
                end else if (!imemReady) begin
                    pcEn        = 1'b0;
                    ifdecBubble = 1'b1;
                    stallInc_s  = 1'b1;
                    nextState_s = ISTALL;
                end else begin
                    nextState_s = RUN;
                end
            end
            DSTALL: begin
                stallInc_s = 1'b1;
                if (dmemReady) begin
                    waitClear_s = 1'b1;
                    nextState_s = RUN;
                end else begin
                    pcEn      = 1'b0;
                    ifdecEn   = 1'b0;
                    decexeEn  = 1'b0;
                    exememEn  = 1'b0;
                    waitInc_s = 1'b1;
                end
            end
            ISTALL: begin
                pcEn        = 1'b0;
                ifdecBubble = 1'b1;
                stallInc_s  = 1'b1;
                if (redirectReq_s) begin
                    decexeBubble     = 1'b1;
                    flushInc_s       = 1'b1;
                    nextPendValid_s  = 1'b1;
                    nextPendTarget_s = target_s;
                end else if (hold) begin
                    ifdecEn      = 1'b0;
                    decexeBubble = 1'b1;
                end else begin
                    ifdecEn = 1'b1;
                end
                if (imemReady) begin
                    nextState_s = RUN;
                    if (redirectReq_s) begin
                        // A fresh redirect on the ready cycle beats the parked one.
                        pcEn            = 1'b1;
                        pcSel           = PC_REDIRECT;
                        pcTarget        = target_s;
                        nextPendValid_s = 1'b0;
                    end else if (pendValid_r) begin
                        pcEn            = 1'b1;
                        pcSel           = PC_REDIRECT;
                        pcTarget        = pendTarget_r;
                        nextPendValid_s = 1'b0;
                    end else begin
                        pcEn = 1'b0;
                    end
                end else begin
                    nextState_s = ISTALL;
                end
            end
            default: begin
                nextState_s = RUN;
            end
        endcase
    end

    // State, parked redirect and sticky timeout registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r      <= RUN;
            pendValid_r  <= 1'b0;
            pendTarget_r <= 32'h0000_0000;
            busError_r   <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            pendValid_r  <= nextPendValid_s;
            pendTarget_r <= nextPendTarget_s;
            busError_r   <= busError_r | timeoutHit_s;
        end
    end

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .Clock  (Clock),
        .nReset (nReset),
        .clear  (1'b0),
        .inc    (flushInc_s),
        .count  (flushCount)
    );

    sat_counter #(.W(CNT_W)) uStallCnt (
        .Clock  (Clock),
        .nReset (nReset),
        .clear  (1'b0),
        .inc    (stallInc_s),
        .count  (stallCount)
    );

    sat_counter #(.W(WAIT_W)) uWaitCnt (
        .Clock  (Clock),
        .nReset (nReset),
        .clear  (waitClear_s),
        .inc    (waitInc_s),
        .count  (waitCount_s)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (DSTALL_TIMEOUT=4, CNT_W=32).
// Each cycle the directed stimulus pushes its expected outputs to a queue;
// the entry is popped and compared at the following falling edge.
module tb_pipeline_sequencer;
    import core_types_pkg::*;

    logic        Clock;
    logic        nReset;
    logic        flush, hold, branch, bypass;
    logic [31:0] PCnext, PCcurrent;
    logic        imemReady, dmemReq, dmemReady;
    logic        pcEn, ifdecEn, decexeEn, exememEn, ifdecBubble, decexeBubble;
    pc_sel_t     pcSel;
    logic [31:0] pcTarget;
    logic        busError;
    logic [31:0] flushCount, stallCount;

    typedef struct packed {
        logic [5:0]  en;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [31:0] fc;
        logic [31:0] sc;
        logic        berr;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] fcExp = 32'd0;
    logic [31:0] scExp = 32'd0;

    // {pcEn, ifdecEn, decexeEn, exememEn, ifdecBubble, decexeBubble}
    localparam logic [5:0] EN_RUN    = 6'b111100;
    localparam logic [5:0] EN_FLUSH  = 6'b111111;
    localparam logic [5:0] EN_HOLDR  = 6'b101101;
    localparam logic [5:0] EN_HOLDP  = 6'b001101;
    localparam logic [5:0] EN_ISTALL = 6'b011110;
    localparam logic [5:0] EN_ICAP   = 6'b011111;
    localparam logic [5:0] EN_IREDIR = 6'b111110;
    localparam logic [5:0] EN_FROZEN = 6'b000000;

    pipeline_sequencer #(.DSTALL_TIMEOUT(4), .CNT_W(32)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .flush        (flush),
        .hold         (hold),
        .branch       (branch),
        .bypass       (bypass),
        .PCnext       (PCnext),
        .PCcurrent    (PCcurrent),
        .imemReady    (imemReady),
        .dmemReq      (dmemReq),
        .dmemReady    (dmemReady),
        .pcEn         (pcEn),
        .ifdecEn      (ifdecEn),
        .decexeEn     (decexeEn),
        .exememEn     (exememEn),
        .ifdecBubble  (ifdecBubble),
        .decexeBubble (decexeBubble),
        .pcSel        (pcSel),
        .pcTarget     (pcTarget),
        .busError     (busError),
        .flushCount   (flushCount),
        .stallCount   (stallCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic setIdle();
        flush = 1'b0; hold = 1'b0; branch = 1'b0; bypass = 1'b0;
        PCnext = 32'h0; PCcurrent = 32'h0;
        imemReady = 1'b1; dmemReq = 1'b0; dmemReady = 1'b0;
    endtask

    // Inputs are already driven; push expectations, compare at the falling
    // edge, then advance to just after the next rising edge.
    task automatic cycle(input string tag, input logic [5:0] en, input logic redir,
                         input logic [31:0] tgt, input logic fInc, input logic sInc,
                         input logic berr);
        exp_t e;
        exp_t got;
        e.en   = en;
        e.sel  = redir ? PC_REDIRECT : PC_SEQ;
        e.tgt  = tgt;
        e.fc   = fcExp;
        e.sc   = scExp;
        e.berr = berr;
        expQ.push_back(e);
        if (fInc) fcExp = fcExp + 32'd1;
        if (sInc) scExp = scExp + 32'd1;
        @(negedge Clock);
        got = expQ.pop_front();
        checkValue({tag, ".en"}, {26'd0, pcEn, ifdecEn, decexeEn, exememEn, ifdecBubble, decexeBubble},
                   {26'd0, got.en});
        checkValue({tag, ".pcSel"}, {30'd0, pcSel}, {30'd0, got.sel});
        checkValue({tag, ".pcTarget"}, pcTarget, got.tgt);
        checkValue({tag, ".flushCount"}, flushCount, got.fc);
        checkValue({tag, ".stallCount"}, stallCount, got.sc);
        checkValue({tag, ".busError"}, {31'd0, busError}, {31'd0, got.berr});
        @(posedge Clock);
        #1;
    endtask

    initial begin
        setIdle();
        nReset = 1'b0;
        // 1: reset held, then released
        cycle("rst_held", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        nReset = 1'b1;
        cycle("rst_rel", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 2: relative flush
        flush = 1'b1; branch = 1'b1; PCcurrent = 32'h100; PCnext = 32'h20;
        cycle("flush_br", EN_FLUSH, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        setIdle();
        cycle("post_flush", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 3: bypass target drops bit 0
        flush = 1'b1; bypass = 1'b1; PCcurrent = 32'h100; PCnext = 32'h203;
        cycle("flush_byp", EN_FLUSH, 1'b1, 32'h202, 1'b1, 1'b0, 1'b0);
        // relative target wraps modulo 2^32
        bypass = 1'b0; branch = 1'b1; PCcurrent = 32'hFFFF_FFF0; PCnext = 32'h20;
        cycle("flush_wrap", EN_FLUSH, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);

        // redirecting hold and pure load-use hold (hold beats I-stall)
        setIdle();
        hold = 1'b1; branch = 1'b1; PCcurrent = 32'h400; PCnext = 32'h10;
        cycle("hold_redir", EN_HOLDR, 1'b1, 32'h410, 1'b0, 1'b0, 1'b0);
        setIdle();
        hold = 1'b1; imemReady = 1'b0;
        cycle("hold_pure", EN_HOLDP, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 5: flush during I-stall is replayed on the ready cycle
        setIdle(); imemReady = 1'b0;
        cycle("istall_in", EN_ISTALL, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1; branch = 1'b1; PCcurrent = 32'h800; PCnext = 32'h40;
        cycle("istall_cap", EN_ICAP, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        setIdle(); imemReady = 1'b0;
        cycle("istall_wait", EN_ISTALL, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        imemReady = 1'b1;
        cycle("istall_rdy", EN_IREDIR, 1'b1, 32'h840, 1'b0, 1'b1, 1'b0);
        cycle("istall_after", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // flush on the ready cycle overwrites the parked target
        imemReady = 1'b0;
        cycle("ist2_in", EN_ISTALL, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1; branch = 1'b1; PCcurrent = 32'h1000; PCnext = 32'h4;
        cycle("ist2_cap", EN_ICAP, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        imemReady = 1'b1; PCcurrent = 32'h2000; PCnext = 32'h8;
        cycle("ist2_win", EN_FLUSH, 1'b1, 32'h2008, 1'b1, 1'b1, 1'b0);
        setIdle();
        cycle("ist2_after", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // reset mid I-stall drops the parked redirect and the counters
        imemReady = 1'b0;
        cycle("ist3_in", EN_ISTALL, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1; branch = 1'b1; PCcurrent = 32'h3000; PCnext = 32'h4;
        cycle("ist3_cap", EN_ICAP, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        setIdle();
        nReset = 1'b0;
        fcExp = 32'd0; scExp = 32'd0;
        cycle("ist3_rst", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        nReset = 1'b1;
        cycle("ist3_nopend", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 6: D-stall timeout of 4 cycles; busError sticky after exit
        dmemReq = 1'b1; dmemReady = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle($sformatf("dto_%0d", k), EN_FROZEN, 1'b0, 32'h0, 1'b0, 1'b1, (k >= 5));
        end
        dmemReady = 1'b1;
        cycle("dto_exit", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        setIdle();
        cycle("dto_sticky", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // 4: flush held through a 5-cycle D-stall is taken only after exit
        dmemReq = 1'b1; dmemReady = 1'b0;
        flush = 1'b1; branch = 1'b1; PCcurrent = 32'h500; PCnext = 32'h30;
        for (int k = 1; k <= 5; k++) begin
            cycle($sformatf("dfl_%0d", k), EN_FROZEN, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        dmemReady = 1'b1;
        cycle("dfl_exit", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        dmemReq = 1'b0; dmemReady = 1'b0;
        cycle("dfl_redir", EN_FLUSH, 1'b1, 32'h530, 1'b1, 1'b0, 1'b1);
        setIdle();
        cycle("final", EN_RUN, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
